// File: rtl/tick_pwm.sv
// tick_pwm: tick-driven PWM generator with a single-entry duty buffer.
// Duty words arrive over a valid/ready handshake and wait in a pending slot.
// They move into the active duty register only at a period boundary, so the
// waveform never changes shape in the middle of a period.
module tick_pwm #(
  parameter int PERIOD = 8,
  parameter int CNT_W  = $clog2(PERIOD),
  parameter int DUTY_W = $clog2(PERIOD + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              pwm_out,
  output logic              period_start
);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DUTY_W-1:0]   duty_act_q, duty_act_d;
  logic [DUTY_W-1:0]   pend_q, pend_d;
  logic                pend_full_q, pend_full_d;
  logic                pwm_q, pwm_d;
  logic                ps_q, ps_d;
  logic                boundary_s;

  // Clamp a requested duty to the period length; anything larger means "always high".
  function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W-1:0] d);
    logic [DUTY_W-1:0] r;
    if (d > DUTY_MAX) begin
      r = DUTY_MAX;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Next-state logic: FSM, position counter, boundary load, handshake and output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    duty_act_d  = duty_act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    ps_d        = 1'b0;
    boundary_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (tick && enable) begin
          state_d    = ST_RUN;
          ps_d       = 1'b1;
          boundary_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (tick) begin
          if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (enable) begin
            cnt_d      = '0;
            ps_d       = 1'b1;
            boundary_s = 1'b1;
          end else begin
            // The period that just finished was the last one; no new start.
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Boundary load uses the pending value from before this edge.
    if (boundary_s && pend_full_q) begin
      duty_act_d  = pend_q;
      pend_full_d = 1'b0;
    end else begin
      duty_act_d = duty_act_q;
    end

    // A handshake can only happen with the slot empty, so it never collides
    // with the boundary load above; a word taken here waits for the next boundary.
    if (duty_valid && !pend_full_q) begin
      pend_d      = sat_duty(duty_in);
      pend_full_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    // Output decoded from next-state values so it moves on the same edge as the counter.
    if (state_d == ST_RUN) begin
      pwm_d = (DUTY_W'(cnt_d) < duty_act_d);
    end else begin
      pwm_d = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      duty_act_q  <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      pwm_q       <= 1'b0;
      ps_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      duty_act_q  <= duty_act_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      pwm_q       <= pwm_d;
      ps_q        <= ps_d;
    end
  end

  assign duty_ready   = !pend_full_q;
  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

endmodule
